usb_rx_decoder: RTL and testbench
=================================

USB_RX_DECODER -- requirements
Module: usb_rx_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per USB bit period.
REQ-002 SHALL have parameter SAMPLE_POINT, default 4, counter value at which the line is sampled (0 < SAMPLE_POINT < CLKS_PER_BIT).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port d_plus_in  input  1  raw USB D+ line, asynchronous to clk.
REQ-006 SHALL have port d_minus_in  input  1  raw USB D- line, asynchronous to clk.
REQ-007 SHALL have port rx_data  output  8  last assembled byte, held until next byte.
REQ-008 SHALL have port rx_data_valid  output  1  one-cycle strobe, rx_data new.
REQ-009 SHALL have port rx_packet_active  output  1  high from SYNC accepted until EOP or error.
REQ-010 SHALL have port rx_eop  output  1  one-cycle strobe, valid EOP received.
REQ-011 SHALL have port rx_error  output  1  one-cycle strobe, packet aborted.

Function
REQ-012 SHALL pass d_plus_in/d_minus_in through a 2-flop synchronizer; all logic uses synchronized values only.
REQ-013 SHALL decode line state: J = (D+1,D-0), K = (0,1), SE0 = (0,0); (1,1) SHALL be treated as SE0.
REQ-014 SHALL run a bit counter 0..CLKS_PER_BIT-1, wrapping; any change of synchronized line state SHALL reload it to 0 (edge resync).
REQ-015 SHALL take one line sample per bit, in the cycle the counter equals SAMPLE_POINT.
REQ-016 SHALL NRZI-decode each non-SE0 sample: bit = 1 if equal to previous sample, else 0; previous sample SHALL be forced to J in IDLE.
REQ-017 SHALL implement states IDLE, SYNC, DATA, EOP, WAIT_IDLE; reset state IDLE.
REQ-018 IDLE: first K sample -> SYNC, counting that bit as sync bit 0 (decoded 0).
REQ-019 SYNC: SHALL require decoded bits 1..6 = 0 and bit 7 = 1; on success -> DATA, rx_packet_active=1, ones-count=1; any mismatch or SE0 -> rx_error, WAIT_IDLE.
REQ-020 DATA: SHALL shift decoded bits LSB-first into an 8-bit register with a 3-bit bit index.
REQ-021 DATA: after six consecutive decoded 1s the next bit SHALL be a stuffed 0, discarded (not shifted, index unchanged); a 1 there -> rx_error, WAIT_IDLE.
REQ-022 Ones-count SHALL reset to 0 on every decoded 0, including stuffed 0s.
REQ-023 On the 8th shifted bit, rx_data and rx_data_valid=1 SHALL update on the clock edge following that sample (latency 1 cycle); index wraps to 0.
REQ-024 DATA: SE0 sample -> EOP if bit index = 0; else rx_error, WAIT_IDLE; SE0 SHALL take priority over stuff checking.
REQ-025 EOP: SHALL require second SE0 sample then J sample -> rx_eop=1, rx_packet_active=0, IDLE; any other sequence -> rx_error, WAIT_IDLE.
REQ-026 WAIT_IDLE: rx_packet_active=0; SHALL return to IDLE after 7 consecutive J samples; any non-J restarts the count.
REQ-027 rx_data_valid, rx_eop, rx_error SHALL be one-cycle pulses, mutually exclusive; rx_error and rx_packet_active falling SHALL occur in the same cycle.
REQ-028 Packets of zero data bytes (SYNC then EOP) SHALL produce rx_eop with no rx_data_valid.

Reset
REQ-029 On rst=1: state IDLE, synchronizer flops to J (1,0), counters 0, rx_data=8'h00, rx_data_valid=0, rx_packet_active=0, rx_eop=0, rx_error=0.
REQ-030 Reset asserted mid-packet SHALL abort with no rx_error/rx_eop pulse; after release, decoding SHALL restart only on a new K in IDLE.

Verification
REQ-031 SYNC, bytes 0xA5, 0x3C, EOP (SE0,SE0,J), 8 clk/bit -> rx_data_valid twice with 0xA5 then 0x3C, then one rx_eop, no rx_error.
REQ-032 SYNC, byte 0xFF with stuffed 0 inserted after 5th data 1 (sync 1 + 5), then 0x7E, EOP -> 0xFF, 0x7E, rx_eop, no rx_error.
REQ-033 SYNC then seven consecutive decoded 1s -> rx_error on the 7th, no rx_data_valid, rx_packet_active falls, IDLE after 7 J bits.
REQ-034 SYNC, 4 data bits, SE0 -> rx_error, no rx_eop; also SYNC with bit 4 = 1 -> rx_error, rx_packet_active never rises.
REQ-035 Bit periods alternating 7 and 9 clocks, byte 0x55 -> rx_data=0x55 correctly; rst pulse during second byte -> all outputs 0, next clean packet decodes normally.

Source files
------------

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder
// Full-speed style USB receive front end: synchronizes the raw D+/D- pair,
// recovers bit timing from line transitions, NRZI-decodes one sample per
// bit, checks SYNC, removes stuffed bits, assembles bytes LSB-first and
// recognises EOP (SE0, SE0, J).  Malformed packets abort with an error
// pulse, after which the receiver waits for 7 idle J bits before it will
// accept a new SYNC.
//
// Ports
//   clk               system clock, all state on the rising edge
//   rst               asynchronous active-high reset
//   d_plus_in         raw D+ line (asynchronous to clk)
//   d_minus_in        raw D- line (asynchronous to clk)
//   rx_data[7:0]      last assembled byte, held until the next byte
//   rx_data_valid     one-cycle strobe, rx_data carries a new byte
//   rx_packet_active  high from accepted SYNC until EOP or error
//   rx_eop            one-cycle strobe, valid EOP received
//   rx_error          one-cycle strobe, packet aborted
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_in,
    input  logic       d_minus_in,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_packet_active,
    output logic       rx_eop,
    output logic       rx_error
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_DATA      = 3'd2,
        ST_EOP       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    logic          dp_meta_r, dp_sync_r, dm_meta_r, dm_sync_r;
    line_t         line_s, line_prev_r;
    logic          edge_s, sample_s, se0_s, samp_k_s, bit_s, abort_s;
    logic [CW-1:0] cnt_r;

    state_t        state_r, state_nx_s;
    logic          prev_k_r, prev_k_nx_s;
    logic [2:0]    idx_r, idx_nx_s;
    logic [2:0]    ones_r, ones_nx_s;
    logic [7:0]    shift_r, shift_nx_s;
    logic          eop_step_r, eop_step_nx_s;
    logic [2:0]    jcnt_r, jcnt_nx_s;
    logic [7:0]    rx_data_r, rx_data_nx_s;
    logic          valid_r, valid_nx_s;
    logic          eop_r, eop_nx_s;
    logic          err_r, err_nx_s;
    logic          active_r, active_nx_s;

    // Two-flop synchronizer; idle line (J) is the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta_r <= 1'b1;
            dp_sync_r <= 1'b1;
            dm_meta_r <= 1'b0;
            dm_sync_r <= 1'b0;
        end else begin
            dp_meta_r <= d_plus_in;
            dp_sync_r <= dp_meta_r;
            dm_meta_r <= d_minus_in;
            dm_sync_r <= dm_meta_r;
        end
    end

    // Line state decode; (1,1) is illegal on the bus and is folded into SE0.
    always_comb begin
        if (dp_sync_r && !dm_sync_r) begin
            line_s = LS_J;
        end else if (!dp_sync_r && dm_sync_r) begin
            line_s = LS_K;
        end else begin
            line_s = LS_SE0;
        end
    end

    assign edge_s   = (line_s != line_prev_r);
    // A transition in the sample cycle means the counter is being re-phased,
    // so that cycle is not a valid mid-bit sample.
    assign sample_s = (cnt_r == CW'(SAMPLE_POINT)) && !edge_s;
    assign se0_s    = (line_s == LS_SE0);
    assign samp_k_s = (line_s == LS_K);
    // NRZI: no change from the previous sample decodes as 1.
    assign bit_s    = (samp_k_s == prev_k_r);

    // Bit-period counter, re-phased to 0 on every line transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_prev_r <= LS_J;
            cnt_r       <= '0;
        end else begin
            line_prev_r <= line_s;
            if (edge_s || (cnt_r == CW'(CLKS_PER_BIT - 1))) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Packet FSM next-state and output logic; only acts on sample cycles.
    always_comb begin
        state_nx_s    = state_r;
        prev_k_nx_s   = prev_k_r;
        idx_nx_s      = idx_r;
        ones_nx_s     = ones_r;
        shift_nx_s    = shift_r;
        eop_step_nx_s = eop_step_r;
        jcnt_nx_s     = jcnt_r;
        rx_data_nx_s  = rx_data_r;
        valid_nx_s    = 1'b0;
        eop_nx_s      = 1'b0;
        err_nx_s      = 1'b0;
        active_nx_s   = active_r;
        abort_s       = 1'b0;
        if (sample_s) begin
            case (state_r)
                ST_IDLE: begin
                    prev_k_nx_s = 1'b0;
                    if (samp_k_s) begin
                        // This K is sync bit 0 (decoded 0 against forced J).
                        state_nx_s  = ST_SYNC;
                        prev_k_nx_s = 1'b1;
                        idx_nx_s    = 3'd1;
                    end else begin
                        state_nx_s  = ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    prev_k_nx_s = samp_k_s;
                    if (se0_s) begin
                        abort_s = 1'b1;
                    end else if (idx_r == 3'd7) begin
                        if (bit_s) begin
                            state_nx_s  = ST_DATA;
                            active_nx_s = 1'b1;
                            ones_nx_s   = 3'd1;   // final sync 1 counts toward stuffing
                            idx_nx_s    = 3'd0;
                        end else begin
                            abort_s = 1'b1;
                        end
                    end else if (bit_s) begin
                        abort_s = 1'b1;
                    end else begin
                        idx_nx_s = idx_r + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (se0_s) begin
                        if (idx_r == 3'd0) begin
                            state_nx_s    = ST_EOP;
                            eop_step_nx_s = 1'b0;
                        end else begin
                            abort_s = 1'b1;
                        end
                    end else begin
                        prev_k_nx_s = samp_k_s;
                        if (ones_r == 3'd6) begin
                            // Stuffed-bit slot: must be 0 and is dropped.
                            if (bit_s) begin
                                abort_s = 1'b1;
                            end else begin
                                ones_nx_s = 3'd0;
                            end
                        end else begin
                            ones_nx_s  = bit_s ? (ones_r + 3'd1) : 3'd0;
                            shift_nx_s = {bit_s, shift_r[7:1]};
                            idx_nx_s   = idx_r + 3'd1;
                            if (idx_r == 3'd7) begin
                                rx_data_nx_s = {bit_s, shift_r[7:1]};
                                valid_nx_s   = 1'b1;
                            end else begin
                                valid_nx_s   = 1'b0;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (!eop_step_r) begin
                        if (se0_s) begin
                            eop_step_nx_s = 1'b1;
                        end else begin
                            abort_s = 1'b1;
                        end
                    end else if (line_s == LS_J) begin
                        eop_nx_s    = 1'b1;
                        active_nx_s = 1'b0;
                        state_nx_s  = ST_IDLE;
                        prev_k_nx_s = 1'b0;
                    end else begin
                        abort_s = 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (line_s == LS_J) begin
                        if (jcnt_r == 3'd6) begin
                            state_nx_s  = ST_IDLE;
                            jcnt_nx_s   = 3'd0;
                            prev_k_nx_s = 1'b0;
                        end else begin
                            jcnt_nx_s = jcnt_r + 3'd1;
                        end
                    end else begin
                        jcnt_nx_s = 3'd0;
                    end
                end
                default: begin
                    state_nx_s  = ST_IDLE;
                    active_nx_s = 1'b0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
        if (abort_s) begin
            err_nx_s    = 1'b1;
            active_nx_s = 1'b0;
            state_nx_s  = ST_WAIT_IDLE;
            jcnt_nx_s   = 3'd0;
            valid_nx_s  = 1'b0;
        end else begin
            err_nx_s    = 1'b0;
        end
    end

    // Packet FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            prev_k_r   <= 1'b0;
            idx_r      <= 3'd0;
            ones_r     <= 3'd0;
            shift_r    <= 8'h00;
            eop_step_r <= 1'b0;
            jcnt_r     <= 3'd0;
            rx_data_r  <= 8'h00;
            valid_r    <= 1'b0;
            eop_r      <= 1'b0;
            err_r      <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            prev_k_r   <= prev_k_nx_s;
            idx_r      <= idx_nx_s;
            ones_r     <= ones_nx_s;
            shift_r    <= shift_nx_s;
            eop_step_r <= eop_step_nx_s;
            jcnt_r     <= jcnt_nx_s;
            rx_data_r  <= rx_data_nx_s;
            valid_r    <= valid_nx_s;
            eop_r      <= eop_nx_s;
            err_r      <= err_nx_s;
            active_r   <= active_nx_s;
        end
    end

    assign rx_data          = rx_data_r;
    assign rx_data_valid    = valid_r;
    assign rx_packet_active = active_r;
    assign rx_eop           = eop_r;
    assign rx_error         = err_r;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder
// Builds USB line symbol streams from byte-level packet descriptions
// (SYNC, NRZI, bit stuffing, EOP), drives them into usb_rx_decoder and
// compares the observed byte / EOP / error events with the packet contents.
module tb_usb_rx_decoder;
    localparam int CPB = 8;
    localparam logic [1:0] LJ  = 2'b10;   // {D+, D-}
    localparam logic [1:0] LK  = 2'b01;
    localparam logic [1:0] L0  = 2'b00;
    localparam logic [1:0] L11 = 2'b11;

    localparam int K_GOOD    = 0;
    localparam int K_SEVEN   = 1;
    localparam int K_SHORT   = 2;
    localparam int K_BADSYNC = 3;
    localparam int K_EOP11   = 4;
    localparam int K_BADEOP  = 5;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       d_plus_in, d_minus_in;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_packet_active, rx_eop, rx_error;

    usb_rx_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(4)) dut (
        .clk              (tb_clk),
        .rst              (rst),
        .d_plus_in        (d_plus_in),
        .d_minus_in       (d_minus_in),
        .rx_data          (rx_data),
        .rx_data_valid    (rx_data_valid),
        .rx_packet_active (rx_packet_active),
        .rx_eop           (rx_eop),
        .rx_error         (rx_error)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        int         kind;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         exp_valid;
        int         exp_eop;
        int         exp_err;
        int         exp_active;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] sym_q[$];
    logic       cur_j;
    int         ones;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         eop_n, err_n;
    logic       active_seen;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge away from DUT updates.
    always @(negedge tb_clk) begin
        if (!rst) begin
            if (rx_data_valid) got_q.push_back(rx_data);
            if (rx_eop) eop_n++;
            if (rx_error) err_n++;
            if (rx_packet_active) active_seen = 1'b1;
            if (rx_data_valid || rx_eop || rx_error) begin
                check("pulse_exclusive", int'(rx_data_valid) + int'(rx_eop) + int'(rx_error), 1);
                if (rx_eop || rx_error) check("active_low_at_end", int'(rx_packet_active), 0);
            end
        end
    end

    // ---- line encoder (reference model) ----
    function automatic void put_bit(input logic d);
        if (!d) cur_j = ~cur_j;               // NRZI: 0 is a transition
        sym_q.push_back(cur_j ? LJ : LK);
    endfunction

    function automatic void put_sync();
        cur_j = 1'b1;
        for (int i = 0; i < 7; i++) put_bit(1'b0);
        put_bit(1'b1);
        ones = 1;
    endfunction

    function automatic void put_data_bit(input logic d);
        if (d) begin
            put_bit(1'b1);
            ones++;
            if (ones == 6) begin
                put_bit(1'b0);
                ones = 0;
            end
        end else begin
            put_bit(1'b0);
            ones = 0;
        end
    endfunction

    function automatic void put_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) put_data_bit(b[i]);
    endfunction

    function automatic void put_eop(input logic [1:0] first);
        sym_q.push_back(first);
        sym_q.push_back(L0);
        sym_q.push_back(LJ);
        cur_j = 1'b1;
    endfunction

    function automatic void put_idle(input int n);
        for (int i = 0; i < n; i++) sym_q.push_back(LJ);
        cur_j = 1'b1;
    endfunction

    function automatic void clear_events();
        got_q.delete();
        exp_q.delete();
        eop_n = 0;
        err_n = 0;
        active_seen = 1'b0;
    endfunction

    // mode 0: CPB clocks per bit; mode 1: alternating 7 / 9 clocks
    task automatic send(input int mode);
        logic [1:0] s;
        int k;
        k = 0;
        while (sym_q.size() > 0) begin
            s = sym_q.pop_front();
            {d_plus_in, d_minus_in} = s;
            repeat ((mode == 1) ? (((k % 2) == 0) ? 7 : 9) : CPB) @(negedge tb_clk);
            k++;
        end
    endtask

    task automatic build(input vec_t v);
        cur_j = 1'b1;
        case (v.kind)
            K_GOOD, K_EOP11, K_BADEOP: begin
                put_sync();
                if (v.nbytes > 0) put_byte(v.b0);
                if (v.nbytes > 1) put_byte(v.b1);
                if (v.kind == K_GOOD) put_eop(L0);
                else if (v.kind == K_EOP11) put_eop(L11);
                else begin
                    sym_q.push_back(L0);
                    sym_q.push_back(LJ);
                end
            end
            K_SEVEN: begin
                put_sync();
                for (int i = 0; i < 6; i++) put_bit(1'b1);
            end
            K_SHORT: begin
                put_sync();
                put_data_bit(1'b1);
                put_data_bit(1'b0);
                put_data_bit(1'b1);
                put_data_bit(1'b1);
                put_eop(L0);
            end
            K_BADSYNC: begin
                for (int i = 0; i < 4; i++) put_bit(1'b0);
                put_bit(1'b1);
                put_bit(1'b0);
                put_bit(1'b0);
                put_bit(1'b1);
            end
            default: put_idle(1);
        endcase
        put_idle(10);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_byte"}, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp_q[i]));
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{K_GOOD,    2, 8'hA5, 8'h3C, 2, 1, 0, 1};
        vecs[1] = '{K_GOOD,    2, 8'hFF, 8'h7E, 2, 1, 0, 1};
        vecs[2] = '{K_GOOD,    0, 8'h00, 8'h00, 0, 1, 0, 1};
        vecs[3] = '{K_SEVEN,   0, 8'h00, 8'h00, 0, 0, 1, 1};
        vecs[4] = '{K_SHORT,   0, 8'h00, 8'h00, 0, 0, 1, 1};
        vecs[5] = '{K_BADSYNC, 0, 8'h00, 8'h00, 0, 0, 1, 0};
        vecs[6] = '{K_EOP11,   1, 8'h00, 8'h00, 1, 1, 0, 1};
        vecs[7] = '{K_BADEOP,  1, 8'h81, 8'h00, 1, 0, 1, 1};
        vecs[8] = '{K_GOOD,    1, 8'h3F, 8'h00, 1, 1, 0, 1};

        rst = 1'b1;
        {d_plus_in, d_minus_in} = LJ;
        clear_events();
        repeat (3) @(negedge tb_clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_valid", int'(rx_data_valid), 0);
        check("reset_active", int'(rx_packet_active), 0);
        check("reset_eop", int'(rx_eop), 0);
        check("reset_error", int'(rx_error), 0);
        rst = 1'b0;
        repeat (20) @(negedge tb_clk);

        // Table-driven packets
        for (int i = 0; i < 9; i++) begin
            clear_events();
            if (vecs[i].exp_valid > 0) exp_q.push_back(vecs[i].b0);
            if (vecs[i].exp_valid > 1) exp_q.push_back(vecs[i].b1);
            build(vecs[i]);
            send(0);
            check_bytes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_eop", i), eop_n, vecs[i].exp_eop);
            check($sformatf("vec%0d_err", i), err_n, vecs[i].exp_err);
            check($sformatf("vec%0d_active", i), int'(active_seen), vecs[i].exp_active);
            if (vecs[i].exp_valid > 0)
                check($sformatf("vec%0d_held", i), int'(rx_data), int'(exp_q[exp_q.size() - 1]));
        end

        // Stuff violation followed by exactly 7 J bits, then a new packet
        clear_events();
        exp_q.push_back(8'h5A);
        put_sync();
        for (int i = 0; i < 6; i++) put_bit(1'b1);
        put_idle(7);
        put_sync();
        put_byte(8'h5A);
        put_eop(L0);
        put_idle(10);
        send(0);
        check("wait7_err", err_n, 1);
        check("wait7_eop", eop_n, 1);
        check_bytes("wait7");

        // Jittered bit periods (7/9 clocks)
        clear_events();
        exp_q.push_back(8'h55);
        put_sync();
        put_byte(8'h55);
        put_eop(L0);
        put_idle(10);
        send(1);
        check_bytes("jitter");
        check("jitter_eop", eop_n, 1);
        check("jitter_err", err_n, 0);

        // Reset during the second byte of a jittered packet
        clear_events();
        exp_q.push_back(8'h55);
        put_sync();
        put_byte(8'h55);
        for (int i = 0; i < 4; i++) put_data_bit(1'b1);
        send(1);
        check_bytes("prereset");
        @(negedge tb_clk);
        rst = 1'b1;
        {d_plus_in, d_minus_in} = LJ;
        repeat (2) @(negedge tb_clk);
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_active", int'(rx_packet_active), 0);
        check("midrst_pulses", int'(rx_data_valid) + int'(rx_eop) + int'(rx_error), 0);
        rst = 1'b0;
        clear_events();
        put_idle(10);
        send(0);
        check("postrst_err", err_n, 0);
        check("postrst_eop", eop_n, 0);
        check("postrst_bytes", got_q.size(), 0);
        clear_events();
        exp_q.push_back(8'hC3);
        put_sync();
        put_byte(8'hC3);
        put_eop(L0);
        put_idle(10);
        send(0);
        check_bytes("postrst_pkt");
        check("postrst_pkt_eop", eop_n, 1);
        check("postrst_pkt_err", err_n, 0);

        // Randomized packets against the encoder model
        for (int r = 0; r < 15; r++) begin
            int n;
            logic [7:0] b;
            clear_events();
            n = $urandom_range(0, 3);
            put_sync();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                put_byte(b);
            end
            put_eop(L0);
            put_idle($urandom_range(8, 16));
            send(0);
            check_bytes($sformatf("rand%0d", r));
            check($sformatf("rand%0d_eop", r), eop_n, 1);
            check($sformatf("rand%0d_err", r), err_n, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
